reg_pl_serializer: RTL and testbench

- Unload side of the parallel-load register family: accepts a parallel word through a valid/ready handshake and shifts it out one bit per enabled clock.
- Produces serial data, a bit-valid strobe and an end-of-word marker.
- Sits between a parallel-load register stage and a serial link or bit-level consumer.
- Supports back-to-back words with no idle cycle.

---
 rtl/reg_pl_serializer_pkg.sv | 24 ++
 rtl/reg_pl_serializer_if.sv | 26 ++
 rtl/reg_pl_bitcnt.sv | 31 +++
 rtl/reg_pl_serializer.sv | 93 +++++++++
 tb/tb_reg_pl_serializer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/reg_pl_serializer_pkg.sv
// Shared types for the parallel-load register family (serializer and deserializer).
// Holds the FSM state encoding and the counter-width helper.
package reg_pl_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to count 0..value-1; never returns less than 1 so a counter always exists.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/reg_pl_serializer_if.sv
// Parallel-in / serial-out bus between an upstream word source, the serializer
// and the bit-level consumer.
interface reg_pl_serializer_if #(
  parameter int width = 8
);

  logic [width-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             enable;
  logic             so_data;
  logic             so_valid;
  logic             so_last;
  logic             busy;

  modport master (
    output d, load_valid, enable,
    input  load_ready, so_data, so_valid, so_last, busy
  );

  modport slave (
    input  d, load_valid, enable,
    output load_ready, so_data, so_valid, so_last, busy
  );

endinterface

// File: rtl/reg_pl_bitcnt.sv
// Modulo-width up counter. It tracks the bit position inside a word and flags the
// final position.
module reg_pl_bitcnt
  import reg_pl_serializer_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     incr,
  output logic [clog2(width)-1:0]  count,
  output logic                     terminal
);

  localparam int cnt_w = clog2(width);

  assign terminal = (count == cnt_w'(width - 1));

  // Clear has priority so a new word restarts at bit 0 even on the retiring edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_pl_serializer.sv
// Unload side of the parallel-load register family: it takes a word over a valid/ready
// handshake and shifts it out one bit per enabled clock. Back-to-back words leave no gap.
module reg_pl_serializer
  import reg_pl_serializer_pkg::*;
#(
  parameter int               width       = 8,
  parameter logic [width-1:0] reset_value = '0,
  parameter bit               msb_first   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_pl_serializer_if.slave   bus
);

  localparam int cnt_w = clog2(width);

  generate
    if (width < 2) begin : g_width_check
      $error("reg_pl_serializer: width must be at least 2");
    end
  endgenerate

  state_t             state;
  state_t             state_next;
  logic [width-1:0]   shreg;
  logic [cnt_w-1:0]   count;
  logic               terminal;
  logic               ready_raw;
  logic               shifting;
  logic               load_fire;
  logic               xfer;
  logic               out_bit;

  assign shifting  = (state == ST_SHIFT);
  assign xfer      = shifting & bus.enable;
  assign load_fire = bus.load_valid & bus.load_ready;
  assign out_bit   = msb_first ? shreg[width-1] : shreg[0];

  // load_ready is masked by reset so that it stays low for the whole reset interval.
  assign bus.load_ready = ready_raw & ~reset;
  assign bus.so_valid   = shifting;
  assign bus.busy       = shifting;
  assign bus.so_data    = shifting & out_bit;
  assign bus.so_last    = shifting & terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // In SHIFT, readiness opens only on the last-bit transfer. That edge can accept the next word.
  always_comb begin
    state_next = state;
    ready_raw  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_raw = 1'b1;
        if (bus.load_valid) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        ready_raw = terminal & bus.enable;
        if (xfer && terminal && !bus.load_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= reset_value;
    end else if (load_fire) begin
      shreg <= bus.d;
    end else if (xfer) begin
      if (msb_first) shreg <= {shreg[width-2:0], 1'b0};
      else           shreg <= {1'b0, shreg[width-1:1]};
    end
  end

  reg_pl_bitcnt #(
    .width (width)
  ) u_bitcnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (load_fire),
    .incr     (xfer),
    .count    (count),
    .terminal (terminal)
  );

endmodule

// File: tb/tb_reg_pl_serializer.sv
// Directed bench for reg_pl_serializer. Expected bits are queued when a word is accepted
// and then checked bit by bit as the DUT shifts them out.
module tb_reg_pl_serializer;

  typedef struct packed {
    logic data;
    logic last;
  } exp_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  bit   active_lsb;
  exp_t sb[$];

  reg_pl_serializer_if #(.width(8)) bus_m ();
  reg_pl_serializer_if #(.width(8)) bus_l ();

  reg_pl_serializer #(.width(8), .reset_value(8'h00), .msb_first(1'b1)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  reg_pl_serializer #(.width(8), .reset_value(8'h00), .msb_first(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] dv);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = active_lsb ? dv[i] : dv[7-i];
      e.last = (i == 7);
      sb.push_back(e);
    end
  endtask

  // Reference model: a non-empty queue means SHIFT is active, and its head holds the bit that should be visible.
  task automatic check_output(input logic lv, input logic [7:0] dv, input logic en, output bit acc);
    logic lr, sv, sd, sl, bz, exp_lr;
    bit   have;
    if (active_lsb) begin
      lr = bus_l.load_ready; sv = bus_l.so_valid; sd = bus_l.so_data;
      sl = bus_l.so_last;    bz = bus_l.busy;
    end else begin
      lr = bus_m.load_ready; sv = bus_m.so_valid; sd = bus_m.so_data;
      sl = bus_m.so_last;    bz = bus_m.busy;
    end
    have   = (sb.size() != 0);
    exp_lr = have ? (sb[0].last & en) : 1'b1;
    check("so_valid", sv, have);
    check("busy", bz, have);
    check("load_ready", lr, exp_lr);
    if (have) begin
      check("so_data", sd, sb[0].data);
      check("so_last", sl, sb[0].last);
      if (en) void'(sb.pop_front());
    end else begin
      check("so_data_idle", sd, 1'b0);
      check("so_last_idle", sl, 1'b0);
    end
    acc = lv & exp_lr;
    if (acc) push_word(dv);
  endtask

  task automatic apply_stimulus(input logic lv, input logic [7:0] dv, input logic en, output bit acc);
    if (active_lsb) begin
      bus_l.load_valid = lv; bus_l.d = dv; bus_l.enable = en;
    end else begin
      bus_m.load_valid = lv; bus_m.d = dv; bus_m.enable = en;
    end
    #1;
    check_output(lv, dv, en, acc);
    @(negedge clk);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, acc);
      n++;
    end
    check("drain_done", sb.size() == 0, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1, acc);
  endtask

  initial begin
    bit acc;
    int n;
    vectors     = 0;
    miscompares = 0;
    active_lsb  = 1'b0;
    reset       = 1'b1;
    bus_m.d = 8'h00; bus_m.load_valid = 1'b0; bus_m.enable = 1'b0;
    bus_l.d = 8'h00; bus_l.load_valid = 1'b0; bus_l.enable = 1'b0;

    @(negedge clk);
    #1;
    check("rst_load_ready", bus_m.load_ready, 1'b0);
    check("rst_so_valid", bus_m.so_valid, 1'b0);
    check("rst_so_data", bus_m.so_data, 1'b0);
    check("rst_busy", bus_m.busy, 1'b0);
    check("rst_lsb_load_ready", bus_l.load_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset released");
    apply_stimulus(1'b0, 8'h00, 1'b1, acc);

    // MSB-first basic word
    apply_stimulus(1'b1, 8'hA5, 1'b1, acc);
    check("accept_a5", acc, 1'b1);
    drain();

    // LSB-first word on the second instance
    active_lsb = 1'b1;
    apply_stimulus(1'b0, 8'h00, 1'b1, acc);
    apply_stimulus(1'b1, 8'h01, 1'b1, acc);
    drain();
    active_lsb = 1'b0;

    // Stall after the second bit
    apply_stimulus(1'b1, 8'hF0, 1'b1, acc);
    repeat (2) apply_stimulus(1'b0, 8'h00, 1'b1, acc);
    repeat (3) apply_stimulus(1'b0, 8'h00, 1'b0, acc);
    drain();

    // Back-to-back words with load_valid held
    apply_stimulus(1'b1, 8'hFF, 1'b1, acc);
    check("b2b_first_accept", acc, 1'b1);
    n = 0;
    do begin
      apply_stimulus(1'b1, 8'h00, 1'b1, acc);
      n++;
    end while (!acc && n < 20);
    check("b2b_second_accept", acc, 1'b1);
    check("b2b_second_at_last_bit", n == 8, 1'b1);
    drain();

    // Reset in the middle of a word
    apply_stimulus(1'b1, 8'hC3, 1'b1, acc);
    repeat (3) apply_stimulus(1'b0, 8'h00, 1'b1, acc);
    #2 reset = 1'b1;
    #1;
    check("midrst_so_valid", bus_m.so_valid, 1'b0);
    check("midrst_busy", bus_m.busy, 1'b0);
    check("midrst_so_data", bus_m.so_data, 1'b0);
    check("midrst_load_ready", bus_m.load_ready, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b1, acc);
    apply_stimulus(1'b1, 8'h81, 1'b1, acc);
    drain();

    // Load attempt while a word is still mid-flight
    apply_stimulus(1'b1, 8'h3C, 1'b1, acc);
    repeat (2) apply_stimulus(1'b0, 8'h00, 1'b1, acc);
    apply_stimulus(1'b1, 8'h55, 1'b1, acc);
    check("ignored_load", acc, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
